// File: rtl/nn_cmd_sequencer_pkg.sv
// rtl/nn_cmd_sequencer_pkg.sv - shared types and codes for the neural-net command sequencer
//
// Package nn_seq_pkg:
//   state_e                      sequencer FSM state
//   OP_NOP/OP_INFER/OP_TRAIN/OP_RSVD   command op codes (cmd_op)
//   ST_OK/ST_ABORT/ST_TIMEOUT          completion status codes (status)
//   op_is_runnable()             1 for the op codes that start a command
package nn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_e;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_INFER = 2'b01;
    localparam logic [1:0] OP_TRAIN = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ABORT   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    function automatic logic op_is_runnable(input logic [1:0] op);
        return (op == OP_INFER) || (op == OP_TRAIN);
    endfunction

endpackage

// File: rtl/nn_cmd_sequencer_if.sv
// rtl/nn_cmd_sequencer_if.sv - command and datapath handshake interfaces
//
// nn_cmd_if #(EPOCH_W): SoC command channel
//   cmd_valid, cmd_op, cmd_epochs  driven by the SoC      (master)
//   cmd_ready                      driven by the sequencer (slave)
// nn_dp_if #(RES_W): datapath control channel
//   nn_start, nn_train             driven by the sequencer (master)
//   nn_done, nn_result             driven by the datapath  (slave)
interface nn_cmd_if #(
    parameter int EPOCH_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [EPOCH_W-1:0] cmd_epochs;

    modport master (output cmd_valid, output cmd_op, output cmd_epochs, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_epochs, output cmd_ready);
endinterface

interface nn_dp_if #(
    parameter int RES_W = 4
);
    logic             nn_start;
    logic             nn_train;
    logic             nn_done;
    logic [RES_W-1:0] nn_result;

    modport master (output nn_start, output nn_train, input nn_done, input nn_result);
    modport slave  (input nn_start, input nn_train, output nn_done, output nn_result);
endinterface

// File: rtl/nn_cmd_sequencer_watchdog.sv
// rtl/nn_cmd_sequencer_watchdog.sv - per-pass cycle watchdog for the command sequencer
//
// Module nn_watchdog #(TIMEOUT):
//   clk, reset   clock, synchronous active-high reset
//   clear_i      restart the count (held while a pass is being started)
//   enable_i     count while waiting for the datapath
//   expired_o    high in the cycle the count sits at TIMEOUT-1 while enabled
module nn_watchdog #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int              CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            // Parks at LIMIT so a stalled enable cannot wrap back to zero.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/nn_cmd_sequencer.sv
// rtl/nn_cmd_sequencer.sv - runs inference / N-epoch training commands on the neural-net datapath
//
// Optional feature macro: NN_WATCHDOG_EN (per-pass timeout, status 10).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   cmd          nn_cmd_if.slave  : cmd_valid/cmd_ready/cmd_op/cmd_epochs
//   dp           nn_dp_if.master  : nn_start/nn_train out, nn_done/nn_result in
//   abort        level, cancels the running command
//   busy         high outside IDLE
//   epoch_cnt    completed passes of the current command
//   result       result captured from the last completed pass
//   status       00 ok, 01 aborted, 10 timeout
//   irq, irq_ack level completion interrupt and its acknowledge
module nn_cmd_sequencer
    import nn_seq_pkg::*;
#(
    parameter int EPOCH_W = 8,
    parameter int RES_W   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               reset,
    nn_cmd_if.slave            cmd,
    nn_dp_if.master            dp,
    input  logic               abort,
    output logic               busy,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic [RES_W-1:0]   result,
    output logic [1:0]         status,
    output logic               irq,
    input  logic               irq_ack
);

    state_e             state_q, state_d;
    logic               train_q, train_d;
    logic [EPOCH_W-1:0] target_q, target_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic [1:0]         status_q, status_d;

    logic               wd_expired;
    logic [EPOCH_W:0]   epoch_inc;
    logic               last_pass;

    // One extra bit so the compare against target never sees a wrapped value.
    assign epoch_inc = {1'b0, epoch_q} + 1'b1;
    assign last_pass = (epoch_inc == {1'b0, target_q});

`ifdef NN_WATCHDOG_EN
    nn_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == START),
        .enable_i  (state_q == WAIT),
        .expired_o (wd_expired)
    );
`else
    // WAIT is unbounded in this build; TIMEOUT only shapes the watchdog.
    assign wd_expired = 1'b0 & (TIMEOUT == 0);
`endif

    always_comb begin
        state_d  = state_q;
        train_d  = train_q;
        target_d = target_q;
        epoch_d  = epoch_q;
        result_d = result_q;
        status_d = status_q;

        case (state_q)
            IDLE: begin
                // Nop and reserved ops complete the handshake but change nothing.
                if (cmd.cmd_valid && op_is_runnable(cmd.cmd_op)) begin
                    train_d  = (cmd.cmd_op == OP_TRAIN);
                    target_d = (cmd.cmd_epochs == '0) ? EPOCH_W'(1) : cmd.cmd_epochs;
                    epoch_d  = '0;
                    status_d = ST_OK;
                    state_d  = START;
                end
            end
            START: begin
                if (abort) begin
                    status_d = ST_ABORT;
                    state_d  = REPORT;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Priority: abort, then a completed pass, then the watchdog.
                if (abort) begin
                    status_d = ST_ABORT;
                    state_d  = REPORT;
                end else if (dp.nn_done) begin
                    result_d = dp.nn_result;
                    if (epoch_q != '1) begin
                        epoch_d = epoch_q + 1'b1;
                    end
                    state_d = (!train_q || last_pass) ? REPORT : START;
                end else if (wd_expired) begin
                    status_d = ST_TIMEOUT;
                    state_d  = REPORT;
                end
            end
            REPORT: begin
                if (irq_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            train_q  <= 1'b0;
            target_q <= '0;
            epoch_q  <= '0;
            result_q <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            train_q  <= train_d;
            target_q <= target_d;
            epoch_q  <= epoch_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    // Moore outputs; nn_train stays up through WAIT and REPORT of a training command.
    assign cmd.cmd_ready = (state_q == IDLE);
    assign dp.nn_start   = (state_q == START);
    assign dp.nn_train   = (state_q != IDLE) && train_q;
    assign busy          = (state_q != IDLE);
    assign irq           = (state_q == REPORT);
    assign epoch_cnt     = epoch_q;
    assign result        = result_q;
    assign status        = status_q;

endmodule
